sha256_msg_packer: RTL
======================

# sha256_msg_packer

Front end of the SHA-256 datapath and the transmitting side of the core's message-word interface. Accepts an arbitrary-length byte stream, applies FIPS 180-4 padding (0x80, zero fill, 64-bit big-endian bit length), and drives each 512-bit block into `SHA256_core` as sixteen 32-bit words. The packer holds each block on `MP_dv_out`/`message_out` in the core's load format. It waits for the core's `core_dv_flag` before issuing the next block of a multi-block message.

## Interface
- `DATA_WIDTH`, 32, word width on `message_out`; only 32 is supported.
- `LEAD_CYCLES`, 3, cycles `MP_dv_out` is high with `message_out`=0 before word 0.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `byte_valid_in` in 1: input byte valid.
- `byte_in` in 8: message byte, first byte is MSB of word 0.
- `byte_last_in` in 1: qualifies the final byte of the message. Messages are at least 1 byte.
- `byte_ready_out` out 1: the packer accepts `byte_in` on an edge where valid&&ready.
- `core_dv_flag_in` in 1: the core's `core_dv_flag`. Its rising edge marks block completion.
- `MP_dv_out` out 1: block load strobe to the core (`MP_dv_in`).
- `message_out` out DATA_WIDTH: word to the core (`message_in`).
- `busy_out` out 1: high in every state except IDLE.

## Operation
- Block buffer: 16×32-bit. Byte counter `blk_idx` is 6 bits and counts 0..63. Message byte counter is 61 bits and wraps mod 2^61. Bit length = counter<<3, 64 bits.
- States and transitions:
  - IDLE: ready=1. The first accepted byte goes to FILL.
  - FILL: ready=1, writes byte at `blk_idx`.
    - Accepting with last=1 goes to PAD.
    - Accepting the 64th byte with last=0 also goes to PAD, with no padding applied.
  - PAD: ready=0, 1 cycle. If the message ended, PAD writes 0x80 at the next byte position and zeroes the rest.
    - If the end position is ≤55, PAD also writes the length into words 14–15 and clears `len_pend`.
    - Otherwise it sets `len_pend`.
    - Next state: SEND.
  - SEND: ready=0, lasts LEAD_CYCLES+16 cycles. `MP_dv_out`=1 throughout.
    - Cycles 0..LEAD_CYCLES-1 drive `message_out`=0.
    - Cycle LEAD_CYCLES+k drives word k.
    - Next state: WAIT_CORE.
  - WAIT_CORE: ready=0, `MP_dv_out`=0, `message_out`=0. The packer waits for a `core_dv_flag_in` rising edge, detected against a registered copy. On that edge:
    - If `len_pend` is set, go to LENBLK.
    - Else if the message ended, go to IDLE and clear the byte counter.
    - Else go to FILL with the buffer cleared and `blk_idx`=0.
  - LENBLK: 1 cycle. Builds the trailing block:
    - Zeros, plus the length in words 14–15.
    - If the previous block ended exactly at byte 64, word 0 = 0x80000000.
    - Clears `len_pend`, then goes to SEND.
- Byte packing is big-endian within each word. Byte i lands in word i/4, bits [31-8*(i%4) -: 8].

## Timing
- Reset values: `MP_dv_out`=0, `message_out`=0, `byte_ready_out`=0 while `rst_n`=0 and 1 in IDLE after release, `busy_out`=0. All counters and flags are 0, and the buffer is cleared.
- Last byte accepted at edge N: PAD during cycle N..N+1. `MP_dv_out` rises after edge N+1 and stays high LEAD_CYCLES+16 cycles. With LEAD_CYCLES=3, it rises at edge N+1 and falls at edge N+20.
- Block-to-block gap is set by the core: the next SEND starts 2 cycles after the `core_dv_flag_in` rising edge (1 cycle edge detect, 1 cycle FILL/LENBLK setup). On a FILL continuation, the gap is instead set by arrival of the next 64 bytes.
- If `core_dv_flag_in` is already high on entry to WAIT_CORE, it is not treated as an edge. Only a 0→1 transition counts.
- A reset asserted mid-SEND drops `MP_dv_out` asynchronously and discards the partial message.

## Configuration
- `SHA_PACKER_PROTO_CHK_EN` defined:
  - Adds output `proto_err_out` (1 bit), sticky, reset 0.
  - It is set when a `core_dv_flag_in` rising edge occurs outside WAIT_CORE.
  - It is also set when `byte_valid_in`&&`byte_last_in`&&ready occurs in IDLE with a zero-length intent, i.e. `byte_last_in` held from reset.
- Undefined: no port and no check logic; stray edges are ignored.

## Structure
- Package `sha256_pkg`: state enum, `WORD_W`=32, `BLK_WORDS`=16, `BLK_BYTES`=64, `PAD_LIMIT`=55, `PAD_BYTE`=8'h80. Shared with the core and the digest-side logic.
- One natural sub-module: `sha256_blk_buf`, a 16-word buffer with byte write, pad/length fill and word read port.

## Test plan
- "abc" (61 62 63, last on 63) → one block: word0=61626380, words1–14=0, word15=00000018. `MP_dv_out` high 19 cycles starting 1 edge after the last accept.
- 56 bytes of 0x41 → block1: words0–13=41414141, word14=80000000, word15=0. After `core_dv_flag_in` pulse, block2: words0–13=0, word14=0, word15=000001C0.
- 64 bytes of 0x00 → block1 all zero, no pad. After the core pulse, block2: word0=80000000, word15=00000200.
- 100-byte message with random valid gaps → `byte_ready_out`=0 during PAD/SEND/WAIT_CORE. No byte is lost. Second block carries the length 00000320 in word15.
- Reset mid-SEND (word 7) → `MP_dv_out`=0 immediately, state IDLE. A following "abc" reproduces the first scenario exactly.
- With `SHA_PACKER_PROTO_CHK_EN`, a `core_dv_flag_in` pulse in FILL → `proto_err_out`=1 and it stays 1 until reset.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: packer FSM states and block geometry constants.
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_PAD,
        ST_SEND,
        ST_WAIT_CORE,
        ST_LENBLK
    } state_t;

    localparam int WORD_W    = 32;
    localparam int BLK_WORDS = 16;
    localparam int BLK_BYTES = 64;
    localparam int PAD_LIMIT = 55;
    localparam logic [7:0] PAD_BYTE = 8'h80;

endpackage

// File: rtl/sha256_blk_buf.sv
// 64-byte block buffer: byte writes, in-place padding/length fill, and a
// big-endian 32-bit word read port.
module sha256_blk_buf
    import sha256_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_wr_en,
    input  logic [5:0]        i_wr_idx,
    input  logic [7:0]        i_wr_byte,
    input  logic              i_pad_en,
    input  logic [6:0]        i_pad_pos,
    input  logic              i_len_en,
    input  logic              i_lenblk_en,
    input  logic              i_lenblk_mark,
    input  logic [63:0]       i_len,
    input  logic [3:0]        i_rd_idx,
    output logic [WORD_W-1:0] o_rd_word
);

    logic [7:0] r_bytes [BLK_BYTES];

    // A pad position of 64 leaves the block untouched; the marker then goes
    // into the trailing length-only block instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < BLK_BYTES; j++) r_bytes[j] <= '0;
        end else if (i_clear || i_lenblk_en) begin
            for (int j = 0; j < BLK_BYTES; j++) r_bytes[j] <= '0;
            if (i_lenblk_en) begin
                for (int k = 0; k < 8; k++) r_bytes[BLK_BYTES-8+k] <= i_len[63-8*k -: 8];
                if (i_lenblk_mark) r_bytes[0] <= PAD_BYTE;
            end
        end else if (i_pad_en) begin
            for (int j = 0; j < BLK_BYTES; j++) begin
                if (7'(j) == i_pad_pos)     r_bytes[j] <= PAD_BYTE;
                else if (7'(j) > i_pad_pos) r_bytes[j] <= '0;
            end
            if (i_len_en) begin
                for (int k = 0; k < 8; k++) r_bytes[BLK_BYTES-8+k] <= i_len[63-8*k -: 8];
            end
        end else if (i_wr_en) begin
            r_bytes[i_wr_idx] <= i_wr_byte;
        end
    end

    assign o_rd_word = {r_bytes[{i_rd_idx, 2'd0}], r_bytes[{i_rd_idx, 2'd1}],
                        r_bytes[{i_rd_idx, 2'd2}], r_bytes[{i_rd_idx, 2'd3}]};

endmodule

// File: rtl/sha256_msg_packer.sv
// SHA-256 message packer: pads a byte stream and streams 512-bit blocks to the core.
// Optional protocol checker enabled by defining SHA_PACKER_PROTO_CHK_EN.
module sha256_msg_packer
    import sha256_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int LEAD_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  byte_valid_in,
    input  logic [7:0]            byte_in,
    input  logic                  byte_last_in,
    output logic                  byte_ready_out,
    input  logic                  core_dv_flag_in,
    output logic                  MP_dv_out,
    output logic [DATA_WIDTH-1:0] message_out,
    output logic                  busy_out
`ifdef SHA_PACKER_PROTO_CHK_EN
    ,
    output logic                  proto_err_out
`endif
);

    localparam int SEND_LEN = LEAD_CYCLES + BLK_WORDS;

    state_t                r_state;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_dv;
    logic [DATA_WIDTH-1:0] r_msg;
    logic [5:0]            r_blk_idx;
    logic [6:0]            r_end_pos;
    logic [60:0]           r_msg_cnt;
    logic                  r_msg_end;
    logic                  r_len_pend;
    logic                  r_mark_pend;
    logic                  r_core_q;
    logic [7:0]            r_send_cnt;

    logic              w_accept;
    logic              w_core_edge;
    logic [7:0]        w_send_nxt;
    logic [3:0]        w_rd_idx;
    logic [WORD_W-1:0] w_rd_word;
    logic              w_pad_en;
    logic              w_len_en;
    logic              w_clear;
    logic              w_lenblk;
    logic [63:0]       w_len;

    assign w_accept    = byte_valid_in && r_ready;
    assign w_core_edge = core_dv_flag_in && !r_core_q;
    assign w_send_nxt  = r_send_cnt + 8'd1;
    assign w_rd_idx    = 4'(w_send_nxt - 8'(LEAD_CYCLES));
    assign w_pad_en    = (r_state == ST_PAD) && r_msg_end;
    assign w_len_en    = w_pad_en && (r_end_pos <= 7'(PAD_LIMIT));
    assign w_clear     = (r_state == ST_WAIT_CORE) && w_core_edge && !r_len_pend;
    assign w_lenblk    = (r_state == ST_LENBLK);
    assign w_len       = {r_msg_cnt, 3'b000};

    sha256_blk_buf u_buf (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clear       (w_clear),
        .i_wr_en       (w_accept),
        .i_wr_idx      (r_blk_idx),
        .i_wr_byte     (byte_in),
        .i_pad_en      (w_pad_en),
        .i_pad_pos     (r_end_pos),
        .i_len_en      (w_len_en),
        .i_lenblk_en   (w_lenblk),
        .i_lenblk_mark (r_mark_pend),
        .i_len         (w_len),
        .i_rd_idx      (w_rd_idx),
        .o_rd_word     (w_rd_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_dv        <= 1'b0;
            r_msg       <= '0;
            r_blk_idx   <= '0;
            r_end_pos   <= '0;
            r_msg_cnt   <= '0;
            r_msg_end   <= 1'b0;
            r_len_pend  <= 1'b0;
            r_mark_pend <= 1'b0;
            r_core_q    <= 1'b0;
            r_send_cnt  <= '0;
        end else begin
            r_core_q <= core_dv_flag_in;
            case (r_state)
                ST_IDLE, ST_FILL: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_msg_cnt <= r_msg_cnt + 61'd1;
                        r_blk_idx <= r_blk_idx + 6'd1;
                        r_end_pos <= {1'b0, r_blk_idx} + 7'd1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_FILL;
                        if (byte_last_in || r_blk_idx == 6'(BLK_BYTES - 1)) begin
                            r_msg_end <= byte_last_in;
                            r_ready   <= 1'b0;
                            r_state   <= ST_PAD;
                        end
                    end
                end
                // No room for the length: defer it (and possibly the marker) to a trailing block.
                ST_PAD: begin
                    if (r_msg_end && !w_len_en) begin
                        r_len_pend  <= 1'b1;
                        r_mark_pend <= (r_end_pos == 7'(BLK_BYTES));
                    end
                    r_dv       <= 1'b1;
                    r_msg      <= '0;
                    r_send_cnt <= '0;
                    r_state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_send_nxt == 8'(SEND_LEN)) begin
                        r_dv    <= 1'b0;
                        r_msg   <= '0;
                        r_state <= ST_WAIT_CORE;
                    end else begin
                        r_send_cnt <= w_send_nxt;
                        r_msg      <= (w_send_nxt >= 8'(LEAD_CYCLES)) ? w_rd_word : '0;
                    end
                end
                ST_WAIT_CORE: begin
                    if (w_core_edge) begin
                        if (r_len_pend) begin
                            r_state <= ST_LENBLK;
                        end else if (r_msg_end) begin
                            r_state   <= ST_IDLE;
                            r_busy    <= 1'b0;
                            r_ready   <= 1'b1;
                            r_msg_cnt <= '0;
                            r_msg_end <= 1'b0;
                            r_blk_idx <= '0;
                        end else begin
                            r_state   <= ST_FILL;
                            r_ready   <= 1'b1;
                            r_blk_idx <= '0;
                        end
                    end
                end
                ST_LENBLK: begin
                    r_len_pend  <= 1'b0;
                    r_mark_pend <= 1'b0;
                    r_dv        <= 1'b1;
                    r_msg       <= '0;
                    r_send_cnt  <= '0;
                    r_state     <= ST_SEND;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign byte_ready_out = r_ready;
    assign MP_dv_out      = r_dv;
    assign message_out    = r_msg;
    assign busy_out       = r_busy;

`ifdef SHA_PACKER_PROTO_CHK_EN
    logic r_proto_err;
    logic r_last_low_seen;

    // A last-qualified first byte is only suspicious if last was never seen low since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_proto_err     <= 1'b0;
            r_last_low_seen <= 1'b0;
        end else begin
            if (!byte_last_in) r_last_low_seen <= 1'b1;
            if ((w_core_edge && r_state != ST_WAIT_CORE) ||
                (w_accept && byte_last_in && r_state == ST_IDLE && !r_last_low_seen))
                r_proto_err <= 1'b1;
        end
    end

    assign proto_err_out = r_proto_err;
`endif

endmodule
